gate_sensor_decoder: RTL and testbench
======================================

# gate_sensor_decoder

Upstream stage of the parking-lot occupancy FSM. Converts two raw beam-break sensors at the single gate lane (outer sensor A, inner sensor B) into clean, single-cycle `enter` / `exit` pulses that drive that FSM's `enter` and `exit` inputs directly. Sensor inputs are synchronised and debounced, and the direction of travel is decoded from the order in which the beams are broken. Aborted, reversed or stalled passages produce no pulse.

## Interface
- `DEBOUNCE`, default 4: consecutive cycles a synchronised sensor level must differ from the debounced level before the debounced level flips. Legal range is 1 or more.
- `TIMEOUT`, default 1000: maximum number of cycles the decoder may stay in one non-idle passage state.
- `CLK` input, 1 bit: the single clock. All logic is on the rising edge.
- `RST` input, 1 bit: asynchronous, active-high reset.
- `sens_a` input, 1 bit: raw outer beam, 1 = broken. Asynchronous to `CLK`.
- `sens_b` input, 1 bit: raw inner beam, 1 = broken. Asynchronous to `CLK`.
- `enter` output, 1 bit: registered one-cycle pulse on completion of an inbound passage.
- `exit` output, 1 bit: registered one-cycle pulse on completion of an outbound passage.
- `fault` output, 1 bit: registered one-cycle pulse when a passage is aborted by an illegal sequence or by timeout.
- `busy` output, 1 bit: registered; high whenever the decoder state is not IDLE.
- `a_db` output, 1 bit: debounced level of sensor A.
- `b_db` output, 1 bit: debounced level of sensor B.

## Operation
- **Reset:** while `RST` is high, all synchroniser flops, debounced levels, counters and outputs are 0, and the state is IDLE. Assertion mid-passage discards the passage and produces no pulse.
- **Synchroniser:** each sensor passes through 2 flops.
- **Debounce:** one counter per sensor, width clog2(DEBOUNCE+1).
  - The counter increments while the synchronised level differs from the debounced level.
  - It clears to 0 on any cycle where they match.
  - When the count reaches DEBOUNCE, the debounced level flips and the counter clears.
- **Direction FSM:** operates on the pair {`a_db`, `b_db`}, written AB. States:
  - IDLE: 10 goes to IN_A; 01 goes to OUT_B; 11 goes to WAIT_CLR with `fault`.
  - IN_A: 11 goes to IN_AB; 00 goes to IDLE (car backed out, no pulse); 01 goes to WAIT_CLR with `fault`.
  - IN_AB: 01 goes to IN_B; 10 goes to IN_A (reversal); 00 goes to WAIT_CLR with `fault`.
  - IN_B: 00 goes to IDLE and pulses `enter`; 11 goes to IN_AB; 10 goes to WAIT_CLR with `fault`.
  - OUT_B, OUT_BA, OUT_A: mirror images of IN_A, IN_AB, IN_B with A and B swapped. Completion from OUT_A on 00 pulses `exit`.
  - WAIT_CLR: stays until 00, then goes to IDLE. No pulse on exit from this state.
  - Any input pair not listed holds the current state.
- **Timeout:**
  - Dwell counter width is clog2(TIMEOUT+1).
  - It clears on every state change and in IDLE and WAIT_CLR.
  - It increments otherwise.
  - At count == TIMEOUT the FSM goes to WAIT_CLR and pulses `fault`.
- **Pulse exclusivity:** `enter`, `exit` and `fault` are mutually exclusive. At most one is high in any cycle, and never on two consecutive cycles.
- **Simultaneous sensor changes:** when both debounced levels flip in the same cycle, the FSM evaluates the resulting pair against the rules above.

## Timing
- Raw edge to debounced edge: a raw level stable before edge k appears on `a_db`/`b_db` after edge k+1+DEBOUNCE, which is 5 edges for the default.
- Debounced pair to state and pulse: 1 cycle. The edge that moves IN_B to IDLE also sets `enter`, and `enter` clears on the next edge. `exit` and `fault` behave the same way.
- `busy` rises on the same edge as the IDLE-to-IN_A or IDLE-to-OUT_B transition. It falls on the same edge as entry to IDLE.
- Shortest complete passage: 4 debounced transitions, giving 4 cycles from the first debounced break to the pulse.
- The downstream FSM samples `enter`/`exit` on the same `CLK`. A one-cycle pulse produces exactly one capacity step.

## Test plan
Settings for all scenarios: DEBOUNCE=4, TIMEOUT=50.
- **Reset:** assert `RST` mid-passage while in IN_AB. Required: all outputs 0 and `busy`=0 immediately (asynchronous); no `enter` after release, even if sensors then clear.
- **Inbound:** raw AB sequence 10, 11, 01, 00, each held 10 cycles. Required: exactly one `enter` pulse, 1 cycle wide, 6 cycles after the final raw clear; `exit`=0 and `fault`=0 throughout.
- **Outbound with glitches:** raw 01, 11, 10, 00, with 2-cycle opposite-level glitches injected on each sensor. Required: `a_db`/`b_db` never toggle on the glitches; exactly one `exit` pulse.
- **Reversal:** raw 10, 11, 10, 00. Required: no pulse; `busy` returns to 0; state ends in IDLE.
- **Illegal sequence:** from IN_A, raw 01. Required: one `fault` pulse; `busy` stays 1 until 00; no `enter`/`exit`.
- **Stall:** hold raw 11 inside a passage for 60 cycles. Required: `fault` 50 cycles after entering IN_AB; next passage after 00 decodes normally.

Source files
------------

// File: rtl/gate_sensor_decoder.sv
// gate_sensor_decoder
// Turns the two raw beam-break sensors of the gate lane (outer A, inner B)
// into clean one-cycle enter / exit / fault pulses for the occupancy FSM.
// Path: 2-flop synchroniser -> per-sensor debounce -> direction FSM with a
// dwell timeout -> registered pulse outputs.

module gate_sensor_decoder #(
  parameter int DEBOUNCE = 4,
  parameter int TIMEOUT  = 1000
) (
  input  logic CLK,
  input  logic RST,
  input  logic sens_a,
  input  logic sens_b,
  output logic enter,
  output logic exit,
  output logic fault,
  output logic busy,
  output logic a_db,
  output logic b_db
);

  localparam int DB_W = $clog2(DEBOUNCE + 1);
  localparam int TO_W = $clog2(TIMEOUT + 1);

  // The debounced level flips on the edge where the mismatch count would
  // reach DEBOUNCE, so compare against DEBOUNCE-1 before incrementing.
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);
  // The dwell counter holds the number of completed cycles in the current
  // state; the TIMEOUT-th cycle is the last one allowed.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_IN_A     = 3'd1,
    S_IN_AB    = 3'd2,
    S_IN_B     = 3'd3,
    S_OUT_B    = 3'd4,
    S_OUT_BA   = 3'd5,
    S_OUT_A    = 3'd6,
    S_WAIT_CLR = 3'd7
  } state_t;

  logic            a_sync_p0, a_sync_p1;
  logic            b_sync_p0, b_sync_p1;
  logic [DB_W-1:0] a_cnt, b_cnt;
  logic [TO_W-1:0] dwell;
  state_t          state, state_nxt;
  logic            enter_nxt, exit_nxt, fault_nxt;
  logic            timed_out;
  logic            pulse_now;
  logic [1:0]      ab;

  // ---- stage p0/p1: two-flop synchronisers for the asynchronous beams ----

  // Capture both raw beams through two flops each to resolve metastability.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_sync_p0 <= 1'b0;
      a_sync_p1 <= 1'b0;
      b_sync_p0 <= 1'b0;
      b_sync_p1 <= 1'b0;
    end else begin
      a_sync_p0 <= sens_a;
      a_sync_p1 <= a_sync_p0;
      b_sync_p0 <= sens_b;
      b_sync_p1 <= b_sync_p0;
    end
  end

  // ---- debounce: level must disagree for DEBOUNCE cycles in a row ----

  // Sensor A debounce: count consecutive mismatches, flip the level on the last.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_cnt <= '0;
      a_db  <= 1'b0;
    end else if (a_sync_p1 == a_db) begin
      a_cnt <= '0;
    end else if (a_cnt == DB_LAST) begin
      a_cnt <= '0;
      a_db  <= ~a_db;
    end else begin
      a_cnt <= a_cnt + DB_W'(1);
    end
  end

  // Sensor B debounce: same behaviour as sensor A.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      b_cnt <= '0;
      b_db  <= 1'b0;
    end else if (b_sync_p1 == b_db) begin
      b_cnt <= '0;
    end else if (b_cnt == DB_LAST) begin
      b_cnt <= '0;
      b_db  <= ~b_db;
    end else begin
      b_cnt <= b_cnt + DB_W'(1);
    end
  end

  // ---- direction FSM on the debounced pair AB ----

  assign ab        = {a_db, b_db};
  assign pulse_now = enter | exit | fault;
  assign timed_out = (state != S_IDLE) && (state != S_WAIT_CLR) && (dwell >= TO_LAST);

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Dwell counter: cleared on any state change and while idle or draining.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dwell <= '0;
    end else if ((state_nxt != state) || (state == S_IDLE) || (state == S_WAIT_CLR)) begin
      dwell <= '0;
    end else begin
      dwell <= dwell + TO_W'(1);
    end
  end

  // Next-state and pulse decode; unlisted pairs hold the current state.
  always_comb begin
    state_nxt = state;
    enter_nxt = 1'b0;
    exit_nxt  = 1'b0;
    fault_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        case (ab)
          2'b10:   state_nxt = S_IN_A;
          2'b01:   state_nxt = S_OUT_B;
          2'b11: begin
            state_nxt = S_WAIT_CLR;
            fault_nxt = 1'b1;
          end
          default: state_nxt = state;
        endcase
      end
      S_IN_A: begin
        case (ab)
          2'b11:   state_nxt = S_IN_AB;
          2'b00:   state_nxt = S_IDLE;
          2'b01: begin
            state_nxt = S_WAIT_CLR;
            fault_nxt = 1'b1;
          end
          default: state_nxt = state;
        endcase
      end
      S_IN_AB: begin
        case (ab)
          2'b01:   state_nxt = S_IN_B;
          2'b10:   state_nxt = S_IN_A;
          2'b00: begin
            state_nxt = S_WAIT_CLR;
            fault_nxt = 1'b1;
          end
          default: state_nxt = state;
        endcase
      end
      S_IN_B: begin
        case (ab)
          2'b00: begin
            state_nxt = S_IDLE;
            enter_nxt = 1'b1;
          end
          2'b11:   state_nxt = S_IN_AB;
          2'b10: begin
            state_nxt = S_WAIT_CLR;
            fault_nxt = 1'b1;
          end
          default: state_nxt = state;
        endcase
      end
      S_OUT_B: begin
        case (ab)
          2'b11:   state_nxt = S_OUT_BA;
          2'b00:   state_nxt = S_IDLE;
          2'b10: begin
            state_nxt = S_WAIT_CLR;
            fault_nxt = 1'b1;
          end
          default: state_nxt = state;
        endcase
      end
      S_OUT_BA: begin
        case (ab)
          2'b10:   state_nxt = S_OUT_A;
          2'b01:   state_nxt = S_OUT_B;
          2'b00: begin
            state_nxt = S_WAIT_CLR;
            fault_nxt = 1'b1;
          end
          default: state_nxt = state;
        endcase
      end
      S_OUT_A: begin
        case (ab)
          2'b00: begin
            state_nxt = S_IDLE;
            exit_nxt  = 1'b1;
          end
          2'b11:   state_nxt = S_OUT_BA;
          2'b01: begin
            state_nxt = S_WAIT_CLR;
            fault_nxt = 1'b1;
          end
          default: state_nxt = state;
        endcase
      end
      S_WAIT_CLR: begin
        if (ab == 2'b00) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    // A stalled passage overrides whatever the sensors are doing.
    if (timed_out) begin
      state_nxt = S_WAIT_CLR;
      enter_nxt = 1'b0;
      exit_nxt  = 1'b0;
      fault_nxt = 1'b1;
    end

    // Pulses may never land on consecutive cycles: if one is on the output
    // now, postpone the pulsing transition by a cycle instead of dropping it.
    if (pulse_now && (enter_nxt || exit_nxt || fault_nxt)) begin
      state_nxt = state;
      enter_nxt = 1'b0;
      exit_nxt  = 1'b0;
      fault_nxt = 1'b0;
    end
  end

  // ---- output registers: pulses and busy share the state-update edge ----

  // Register the pulses and busy so they change on the same edge as the state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      enter <= 1'b0;
      exit  <= 1'b0;
      fault <= 1'b0;
      busy  <= 1'b0;
    end else begin
      enter <= enter_nxt;
      exit  <= exit_nxt;
      fault <= fault_nxt;
      busy  <= (state_nxt != S_IDLE);
    end
  end

endmodule

// File: tb/tb_gate_sensor_decoder.sv
// Directed bench for gate_sensor_decoder with DEBOUNCE=4, TIMEOUT=50.
// Raw levels are driven 1 time unit after a rising edge; outputs are observed
// on the falling edge by a monitor that logs pulse counts and event cycles.

module tb_gate_sensor_decoder;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic sens_a = 1'b0;
  logic sens_b = 1'b0;
  logic enter, exit, fault, busy, a_db, b_db;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  // monitor state
  int   n_enter = 0, n_exit = 0, n_fault = 0, n_excl = 0;
  int   t_enter = -1, t_exit = -1, t_fault = -1;
  int   n_atog = 0, n_btog = 0;
  int   t_a_rise = -1, t_busy_rise = -1;
  logic a_prev = 1'b0, b_prev = 1'b0, busy_prev = 1'b0, pulse_prev = 1'b0;

  gate_sensor_decoder #(.DEBOUNCE(4), .TIMEOUT(50)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .sens_a(sens_a),
    .sens_b(sens_b),
    .enter (enter),
    .exit  (exit),
    .fault (fault),
    .busy  (busy),
    .a_db  (a_db),
    .b_db  (b_db)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (enter) begin n_enter <= n_enter + 1; t_enter <= cyc; end
    if (exit)  begin n_exit  <= n_exit + 1;  t_exit  <= cyc; end
    if (fault) begin n_fault <= n_fault + 1; t_fault <= cyc; end
    if ((int'(enter) + int'(exit) + int'(fault)) > 1 || (pulse_prev && (enter || exit || fault)))
      n_excl <= n_excl + 1;
    pulse_prev <= enter | exit | fault;
    if (a_db !== a_prev) n_atog <= n_atog + 1;
    if (b_db !== b_prev) n_btog <= n_btog + 1;
    if (a_db && !a_prev) t_a_rise <= cyc;
    if (busy && !busy_prev) t_busy_rise <= cyc;
    a_prev    <= a_db;
    b_prev    <= b_db;
    busy_prev <= busy;
  end

  // Call right after a rising edge: set raw AB 1 unit later, hold for n edges.
  task automatic drive(input logic [1:0] ab, input int n, output int c);
    #1;
    {sens_a, sens_b} = ab;
    c = cyc;
    repeat (n) @(posedge CLK);
  endtask

  task automatic drive_glitched(input logic [1:0] ab, output int c);
    int d;
    drive(ab, 10, c);
    drive(ab ^ 2'b10, 2, d);
    drive(ab, 3, d);
    drive(ab ^ 2'b01, 2, d);
    drive(ab, 3, d);
  endtask

  task automatic test_reset;
    #1 RST = 1'b1;
    repeat (3) @(posedge CLK);
    #2;
    total++;
    if ({enter, exit, fault, busy, a_db, b_db} !== 6'b0)
      $display("FAIL reset_outputs: got %b want 000000", {enter, exit, fault, busy, a_db, b_db});
    else passed++;
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
  endtask

  task automatic test_inbound;
    int c1, c2, c3, c4, s_en, s_ex, s_fl;
    s_en = n_enter; s_ex = n_exit; s_fl = n_fault;
    drive(2'b10, 10, c1);
    drive(2'b11, 10, c2);
    drive(2'b01, 10, c3);
    drive(2'b00, 10, c4);
    total++;
    if (t_a_rise !== c1 + 6) $display("FAIL in_a_db_rise: cycle %0d want %0d", t_a_rise, c1 + 6);
    else passed++;
    total++;
    if (t_busy_rise !== c1 + 7) $display("FAIL in_busy_rise: cycle %0d want %0d", t_busy_rise, c1 + 7);
    else passed++;
    total++;
    if (n_enter - s_en !== 1) $display("FAIL in_enter_count: got %0d want 1", n_enter - s_en);
    else passed++;
    total++;
    if (t_enter !== c4 + 7) $display("FAIL in_enter_time: cycle %0d want %0d", t_enter, c4 + 7);
    else passed++;
    total++;
    if ((n_exit - s_ex) + (n_fault - s_fl) !== 0)
      $display("FAIL in_no_exit_fault: got %0d want 0", (n_exit - s_ex) + (n_fault - s_fl));
    else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL in_busy_end: got %b want 0", busy);
    else passed++;
  endtask

  task automatic test_outbound_glitch;
    int c1, c2, c3, c4, s_en, s_ex, s_fl, s_at, s_bt;
    s_en = n_enter; s_ex = n_exit; s_fl = n_fault; s_at = n_atog; s_bt = n_btog;
    drive_glitched(2'b01, c1);
    drive_glitched(2'b11, c2);
    drive_glitched(2'b10, c3);
    drive_glitched(2'b00, c4);
    total++;
    if (n_atog - s_at !== 2) $display("FAIL out_a_toggles: got %0d want 2", n_atog - s_at);
    else passed++;
    total++;
    if (n_btog - s_bt !== 2) $display("FAIL out_b_toggles: got %0d want 2", n_btog - s_bt);
    else passed++;
    total++;
    if (n_exit - s_ex !== 1) $display("FAIL out_exit_count: got %0d want 1", n_exit - s_ex);
    else passed++;
    total++;
    if (t_exit !== c4 + 7) $display("FAIL out_exit_time: cycle %0d want %0d", t_exit, c4 + 7);
    else passed++;
    total++;
    if ((n_enter - s_en) + (n_fault - s_fl) !== 0)
      $display("FAIL out_no_enter_fault: got %0d want 0", (n_enter - s_en) + (n_fault - s_fl));
    else passed++;
  endtask

  task automatic test_reversal;
    int c, s_en, s_ex, s_fl;
    s_en = n_enter; s_ex = n_exit; s_fl = n_fault;
    drive(2'b10, 10, c);
    drive(2'b11, 10, c);
    total++;
    if (busy !== 1'b1) $display("FAIL rev_busy_mid: got %b want 1", busy);
    else passed++;
    drive(2'b10, 10, c);
    drive(2'b00, 10, c);
    total++;
    if ((n_enter - s_en) + (n_exit - s_ex) + (n_fault - s_fl) !== 0)
      $display("FAIL rev_no_pulse: got %0d want 0", (n_enter - s_en) + (n_exit - s_ex) + (n_fault - s_fl));
    else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL rev_busy_end: got %b want 0", busy);
    else passed++;
  endtask

  task automatic test_illegal;
    int c1, c2, c3, s_en, s_ex, s_fl;
    s_en = n_enter; s_ex = n_exit; s_fl = n_fault;
    drive(2'b10, 10, c1);
    drive(2'b01, 10, c2);
    total++;
    if (n_fault - s_fl !== 1) $display("FAIL ill_fault_count: got %0d want 1", n_fault - s_fl);
    else passed++;
    total++;
    if (t_fault !== c2 + 7) $display("FAIL ill_fault_time: cycle %0d want %0d", t_fault, c2 + 7);
    else passed++;
    total++;
    if (busy !== 1'b1) $display("FAIL ill_busy_held: got %b want 1", busy);
    else passed++;
    drive(2'b00, 10, c3);
    total++;
    if (busy !== 1'b0) $display("FAIL ill_busy_clear: got %b want 0", busy);
    else passed++;
    total++;
    if ((n_enter - s_en) + (n_exit - s_ex) !== 0)
      $display("FAIL ill_no_enter_exit: got %0d want 0", (n_enter - s_en) + (n_exit - s_ex));
    else passed++;
  endtask

  task automatic test_stall;
    int c1, c2, c3, s_en, s_fl;
    s_fl = n_fault;
    drive(2'b10, 10, c1);
    drive(2'b11, 60, c2);
    // IN_AB is entered on edge c2+7; the timeout fires 50 edges later.
    total++;
    if (t_fault !== c2 + 57) $display("FAIL stall_fault_time: cycle %0d want %0d", t_fault, c2 + 57);
    else passed++;
    total++;
    if (n_fault - s_fl !== 1) $display("FAIL stall_fault_count: got %0d want 1", n_fault - s_fl);
    else passed++;
    drive(2'b00, 10, c3);
    total++;
    if (busy !== 1'b0) $display("FAIL stall_busy_clear: got %b want 0", busy);
    else passed++;
    s_en = n_enter;
    drive(2'b10, 10, c3);
    drive(2'b11, 10, c3);
    drive(2'b01, 10, c3);
    drive(2'b00, 10, c3);
    total++;
    if (n_enter - s_en !== 1) $display("FAIL stall_next_enter: got %0d want 1", n_enter - s_en);
    else passed++;
    total++;
    if (t_enter !== c3 + 7) $display("FAIL stall_next_time: cycle %0d want %0d", t_enter, c3 + 7);
    else passed++;
  endtask

  task automatic test_reset_mid;
    int c, s_en, s_ex, s_fl;
    drive(2'b10, 10, c);
    drive(2'b11, 10, c);
    total++;
    if (busy !== 1'b1) $display("FAIL rstmid_busy_before: got %b want 1", busy);
    else passed++;
    #2 RST = 1'b1;
    #1;
    total++;
    if ({enter, exit, fault, busy, a_db, b_db} !== 6'b0)
      $display("FAIL rstmid_async_clear: got %b want 000000", {enter, exit, fault, busy, a_db, b_db});
    else passed++;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    s_en = n_enter; s_ex = n_exit; s_fl = n_fault;
    drive(2'b01, 10, c);
    drive(2'b00, 10, c);
    total++;
    if (n_enter - s_en !== 0) $display("FAIL rstmid_no_enter: got %0d want 0", n_enter - s_en);
    else passed++;
    total++;
    if ((n_exit - s_ex) + (n_fault - s_fl) !== 0)
      $display("FAIL rstmid_no_other: got %0d want 0", (n_exit - s_ex) + (n_fault - s_fl));
    else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL rstmid_busy_end: got %b want 0", busy);
    else passed++;
  endtask

  task automatic test_exclusive;
    total++;
    if (n_excl !== 0) $display("FAIL pulse_exclusive: violations %0d want 0", n_excl);
    else passed++;
  endtask

  initial begin
    test_reset;
    test_inbound;
    test_outbound_glitch;
    test_reversal;
    test_illegal;
    test_stall;
    test_reset_mid;
    test_exclusive;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
